// File: rtl/conv_window_gen_pkg.sv
// Shared constants, FSM encoding and window slot helper for the 3x3 window generator.
// The top level overrides IMG_W/IMG_H through its own parameters; PIX_W/IDX_W are fixed here.
package conv_pkg;

   localparam int IMG_W = 416;
   localparam int IMG_H = 416;
   localparam int PIX_W = 8;
   localparam int IDX_W = 9;
   localparam int PAD_W = IMG_W + 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Window element (r,c) lives in slot 3r+c of a channel's 9-pixel bus.
   function automatic int slot(input int r, input int c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/conv_window_gen_win_mux3x3.sv
// Combinational 3x3 window selector for one colour channel.
// Picks padded columns col_sel..col_sel+2 from three packed rows.
module win_mux3x3
   import conv_pkg::*;
#(
   parameter int NPIX = PAD_W
) (
   input  logic [NPIX*PIX_W-1:0] row0,
   input  logic [NPIX*PIX_W-1:0] row1,
   input  logic [NPIX*PIX_W-1:0] row2,
   input  logic [IDX_W-1:0]      col_sel,
   output logic [9*PIX_W-1:0]    win
);

   always_comb begin
      win = '0;
      for (int c = 0; c < 3; c++) begin
         win[slot(0, c)*PIX_W +: PIX_W] = row0[(int'(col_sel) + c)*PIX_W +: PIX_W];
         win[slot(1, c)*PIX_W +: PIX_W] = row1[(int'(col_sel) + c)*PIX_W +: PIX_W];
         win[slot(2, c)*PIX_W +: PIX_W] = row2[(int'(col_sel) + c)*PIX_W +: PIX_W];
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Slides a 3x3x3 window across three stable padded rows, one column per handshake.
// Handshake: a transfer happens on a rising edge where valid&ready; valid never drops without a transfer.
module conv_window_gen #(
   parameter int  IMG_W = conv_pkg::IMG_W,
   parameter int  IMG_H = conv_pkg::IMG_H,
   localparam int PIX_W = conv_pkg::PIX_W,
   localparam int IDX_W = conv_pkg::IDX_W,
   localparam int PAD_W = IMG_W + 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   row_valid,
   output logic                   row_ready,
   input  logic [PAD_W*PIX_W-1:0] R_row0,
   input  logic [PAD_W*PIX_W-1:0] G_row0,
   input  logic [PAD_W*PIX_W-1:0] B_row0,
   input  logic [PAD_W*PIX_W-1:0] R_row1,
   input  logic [PAD_W*PIX_W-1:0] G_row1,
   input  logic [PAD_W*PIX_W-1:0] B_row1,
   input  logic [PAD_W*PIX_W-1:0] R_row2,
   input  logic [PAD_W*PIX_W-1:0] G_row2,
   input  logic [PAD_W*PIX_W-1:0] B_row2,
   output logic                   win_valid,
   input  logic                   win_ready,
   output logic [9*PIX_W-1:0]     R_win,
   output logic [9*PIX_W-1:0]     G_win,
   output logic [9*PIX_W-1:0]     B_win,
   output logic [IDX_W-1:0]       col,
   output logic [IDX_W-1:0]       row_idx,
   output logic                   pass_done,
   output logic                   frame_done,
   output conv_pkg::state_t       dbg_state
);

   localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(IMG_W - 1);
   localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(IMG_H - 1);

   conv_pkg::state_t state, state_next;

   logic                 win_load;
   logic [IDX_W-1:0]     col_next;
   logic [IDX_W-1:0]     row_next;
   logic                 win_valid_next;
   logic                 pass_next;
   logic                 frame_next;
   logic [IDX_W-1:0]     col_sel;
   logic [9*PIX_W-1:0]   r_mux, g_mux, b_mux;

   assign dbg_state = state;

   // The mux always looks at the column that would be registered next.
   assign col_sel = (state == conv_pkg::SCAN && col != LAST_COL) ? col + IDX_W'(1) : '0;

   win_mux3x3 #(.NPIX(PAD_W)) u_mux_r (
      .row0(R_row0), .row1(R_row1), .row2(R_row2), .col_sel(col_sel), .win(r_mux)
   );
   win_mux3x3 #(.NPIX(PAD_W)) u_mux_g (
      .row0(G_row0), .row1(G_row1), .row2(G_row2), .col_sel(col_sel), .win(g_mux)
   );
   win_mux3x3 #(.NPIX(PAD_W)) u_mux_b (
      .row0(B_row0), .row1(B_row1), .row2(B_row2), .col_sel(col_sel), .win(b_mux)
   );

   always_comb begin
      state_next     = state;
      win_load       = 1'b0;
      col_next       = col;
      row_next       = row_idx;
      win_valid_next = win_valid;
      pass_next      = 1'b0;
      frame_next     = 1'b0;
      case (state)
         conv_pkg::IDLE: begin
            if (row_valid && row_ready) begin
               state_next     = conv_pkg::SCAN;
               win_load       = 1'b1;
               col_next       = '0;
               win_valid_next = 1'b1;
            end
         end
         conv_pkg::SCAN: begin
            if (win_valid && win_ready) begin
               if (col == LAST_COL) begin
                  state_next     = conv_pkg::DONE;
                  win_valid_next = 1'b0;
                  col_next       = '0;
                  pass_next      = 1'b1;
                  frame_next     = (row_idx == LAST_ROW);
               end else begin
                  col_next = col + IDX_W'(1);
                  win_load = 1'b1;
               end
            end
         end
         conv_pkg::DONE: begin
            state_next = conv_pkg::IDLE;
            row_next   = (row_idx == LAST_ROW) ? '0 : row_idx + IDX_W'(1);
         end
         default: state_next = conv_pkg::IDLE;
      endcase
   end

   // row_ready is registered so it stays low throughout reset and rises one cycle after release.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= conv_pkg::IDLE;
         row_ready  <= 1'b0;
         win_valid  <= 1'b0;
         col        <= '0;
         row_idx    <= '0;
         pass_done  <= 1'b0;
         frame_done <= 1'b0;
         R_win      <= '0;
         G_win      <= '0;
         B_win      <= '0;
      end else begin
         state      <= state_next;
         row_ready  <= (state_next == conv_pkg::IDLE);
         win_valid  <= win_valid_next;
         col        <= col_next;
         row_idx    <= row_next;
         pass_done  <= pass_next;
         frame_done <= frame_next;
         if (win_load) begin
            R_win <= r_mux;
            G_win <= g_mux;
            B_win <= b_mux;
         end
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: full-width rows, short frame height for wrap coverage.
// Expected windows are computed from the bench's own pixel function and queued per pass.
module tb_conv_window_gen;

   localparam int IMG_W = 416;
   localparam int IMG_H = 4;
   localparam int PIX_W = 8;
   localparam int IDX_W = 9;
   localparam int PAD_W = IMG_W + 2;
   localparam int WW    = 9 * PIX_W;
   localparam int SBW   = IDX_W + 3 * WW;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic                   row_valid = 1'b0;
   logic                   row_ready;
   logic [PAD_W*PIX_W-1:0] R_row0, G_row0, B_row0;
   logic [PAD_W*PIX_W-1:0] R_row1, G_row1, B_row1;
   logic [PAD_W*PIX_W-1:0] R_row2, G_row2, B_row2;
   logic                   win_valid;
   logic                   win_ready = 1'b1;
   logic [WW-1:0]          R_win, G_win, B_win;
   logic [IDX_W-1:0]       col, row_idx;
   logic                   pass_done, frame_done;
   logic [1:0]             dbg_state;

   conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk(clk), .reset(reset),
      .row_valid(row_valid), .row_ready(row_ready),
      .R_row0(R_row0), .G_row0(G_row0), .B_row0(B_row0),
      .R_row1(R_row1), .G_row1(G_row1), .B_row1(B_row1),
      .R_row2(R_row2), .G_row2(G_row2), .B_row2(B_row2),
      .win_valid(win_valid), .win_ready(win_ready),
      .R_win(R_win), .G_win(G_win), .B_win(B_win),
      .col(col), .row_idx(row_idx),
      .pass_done(pass_done), .frame_done(frame_done),
      .dbg_state(dbg_state)
   );

   int total = 0;
   int bad   = 0;
   logic [SBW-1:0] exp_q[$];

   typedef struct {
      int seed;
      int stall_col;
      int stall_len;
      bit hold_valid;
      bit rnd_ready;
      int abort_col;
      int exp_row;
      bit exp_frame;
   } pass_t;

   pass_t tbl[7];

   function automatic logic [7:0] pix(input int ch, input int r, input int k, input int seed);
      return 8'((r * 16 + k + ch * 85 + seed * 7) % 256);
   endfunction

   function automatic logic [WW-1:0] exp_win(input int ch, input int c0, input int seed);
      logic [WW-1:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[PIX_W*(3*r+c) +: PIX_W] = pix(ch, r, c0 + c, seed);
      return w;
   endfunction

   function automatic logic [WW-1:0] pack9(input int v[9]);
      logic [WW-1:0] w;
      w = '0;
      for (int s = 0; s < 9; s++) w[PIX_W*s +: PIX_W] = 8'(v[s]);
      return w;
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_rows(input int seed);
      for (int k = 0; k < PAD_W; k++) begin
         R_row0[PIX_W*k +: PIX_W] = pix(0, 0, k, seed);
         R_row1[PIX_W*k +: PIX_W] = pix(0, 1, k, seed);
         R_row2[PIX_W*k +: PIX_W] = pix(0, 2, k, seed);
         G_row0[PIX_W*k +: PIX_W] = pix(1, 0, k, seed);
         G_row1[PIX_W*k +: PIX_W] = pix(1, 1, k, seed);
         G_row2[PIX_W*k +: PIX_W] = pix(1, 2, k, seed);
         B_row0[PIX_W*k +: PIX_W] = pix(2, 0, k, seed);
         B_row1[PIX_W*k +: PIX_W] = pix(2, 1, k, seed);
         B_row2[PIX_W*k +: PIX_W] = pix(2, 2, k, seed);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {win_valid, row_ready, pass_done, frame_done, col, row_idx, R_win, G_win, B_win}, '0);
   endtask

   task automatic run_pass(input pass_t p);
      int  n;
      int  stall;
      int  cyc;
      bit  done;
      int  first_r[9];
      int  last_r[9];
      first_r = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
      last_r  = '{159, 160, 161, 175, 176, 177, 191, 192, 193};

      load_rows(p.seed);
      n = 0;
      while (!row_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("row_ready before pass", row_ready, 1);
      check("row_idx at pass start", row_idx, p.exp_row);

      row_valid = 1'b1;
      for (int c = 0; c < IMG_W; c++)
         exp_q.push_back({IDX_W'(c), exp_win(0, c, p.seed), exp_win(1, c, p.seed), exp_win(2, c, p.seed)});
      @(negedge clk);
      if (!p.hold_valid) row_valid = 1'b0;
      check("first window latency", {win_valid, col}, {1'b1, IDX_W'(0)});
      if (p.seed == 0) check("first R window values", R_win, pack9(first_r));

      stall = 0;
      cyc   = 0;
      done  = 1'b0;
      while (!done && cyc < 5000) begin
         if (p.abort_col >= 0 && win_valid && int'(col) == p.abort_col) begin
            reset = 1'b0;
            @(negedge clk);
            check_reset_outputs("mid-scan reset outputs");
            exp_q.delete();
            reset     = 1'b1;
            row_valid = 1'b0;
            @(negedge clk);
            check("after abort ready/no pass_done", {row_ready, pass_done, win_valid, row_idx}, {1'b1, 1'b0, 1'b0, IDX_W'(0)});
            done = 1'b1;
         end else if (pass_done) begin
            row_valid = 1'b0;
            check("pass end frame_done/all windows", {frame_done, exp_q.size() == 0}, {p.exp_frame, 1'b1});
            check("row_idx during pass_done", row_idx, p.exp_row);
            win_ready = 1'b1;
            @(negedge clk);
            check("pass_done one cycle", {pass_done, frame_done, win_valid}, 3'b000);
            check("row_idx after pass", row_idx, (p.exp_row + 1) % IMG_H);
            done = 1'b1;
         end else begin
            check("win_valid held until done", win_valid, 1);
            if (win_valid) begin
               if (exp_q.size() > 0)
                  check("window", {col, R_win, G_win, B_win}, exp_q[0]);
               else
                  check("unexpected extra window", 1, 0);
               if (p.seed == 0 && int'(col) == IMG_W - 1)
                  check("last R window values", R_win, pack9(last_r));
            end
            if (int'(col) == p.stall_col && stall < p.stall_len) begin
               win_ready = 1'b0;
               stall++;
            end else if (p.rnd_ready) begin
               win_ready = ($urandom_range(0, 3) != 0);
            end else begin
               win_ready = 1'b1;
            end
            if (win_valid && win_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            @(negedge clk);
            cyc++;
         end
      end
      check("pass finished within budget", done, 1);
      win_ready = 1'b1;
      row_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{seed: 0, stall_col: -1,  stall_len: 0, hold_valid: 0, rnd_ready: 0, abort_col: -1,  exp_row: 0, exp_frame: 0};
      tbl[1] = '{seed: 1, stall_col: 100, stall_len: 5, hold_valid: 0, rnd_ready: 0, abort_col: -1,  exp_row: 1, exp_frame: 0};
      tbl[2] = '{seed: 2, stall_col: -1,  stall_len: 0, hold_valid: 1, rnd_ready: 1, abort_col: -1,  exp_row: 2, exp_frame: 0};
      tbl[3] = '{seed: 3, stall_col: 7,   stall_len: 2, hold_valid: 0, rnd_ready: 1, abort_col: -1,  exp_row: 3, exp_frame: 1};
      tbl[4] = '{seed: 4, stall_col: -1,  stall_len: 0, hold_valid: 1, rnd_ready: 0, abort_col: -1,  exp_row: 0, exp_frame: 0};
      tbl[5] = '{seed: 5, stall_col: -1,  stall_len: 0, hold_valid: 0, rnd_ready: 0, abort_col: 200, exp_row: 1, exp_frame: 0};
      tbl[6] = '{seed: 6, stall_col: 415, stall_len: 3, hold_valid: 0, rnd_ready: 0, abort_col: -1,  exp_row: 0, exp_frame: 0};

      load_rows(0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_reset_outputs("outputs during reset");
      end
      reset = 1'b1;
      @(negedge clk);
      check("ready after reset release", {row_ready, win_valid}, 2'b10);

      for (int i = 0; i < 7; i++) run_pass(tbl[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
